// File: rtl/nurn_upd_pkg.sv
// Shared constants for the neuron state update engine: FSM encoding and
// status-word selectors used to build {nurnIdx, sel} status memory addresses.
package nurn_upd_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_RD_B = 4'd1;
    localparam state_t ST_RD_P = 4'd2;
    localparam state_t ST_RD_T = 4'd3;
    localparam state_t ST_RD_H = 4'd4;
    localparam state_t ST_SYN  = 4'd5;
    localparam state_t ST_CALC = 4'd6;
    localparam state_t ST_WR_P = 4'd7;
    localparam state_t ST_WR_H = 4'd8;

    localparam logic [1:0] SEL_BIAS = 2'b00;
    localparam logic [1:0] SEL_POT  = 2'b01;
    localparam logic [1:0] SEL_TH   = 2'b10;
    localparam logic [1:0] SEL_HIST = 2'b11;

endpackage

// File: rtl/nurn_sat_add3.sv
// Three-operand signed add with saturation to DSIZE bits, followed by a
// signed threshold compare on the saturated result.
module nurn_sat_add3 #(
    parameter int DSIZE = 16
) (
    input  logic signed [DSIZE-1:0] opA_i,
    input  logic signed [DSIZE-1:0] opB_i,
    input  logic signed [DSIZE-1:0] opC_i,
    input  logic signed [DSIZE-1:0] th_i,
    output logic signed [DSIZE-1:0] sum_o,
    output logic                    fire_o
);

    // Two guard bits are enough for the sum of three DSIZE-bit operands.
    localparam logic signed [DSIZE+1:0] SatMax = $signed({3'b000, {(DSIZE-1){1'b1}}});
    localparam logic signed [DSIZE+1:0] SatMin = $signed({3'b111, {(DSIZE-1){1'b0}}});

    logic signed [DSIZE+1:0] wide;

    // Widen, add, clamp to the representable range, then compare against threshold.
    always_comb begin
        wide = {{2{opA_i[DSIZE-1]}}, opA_i} + {{2{opB_i[DSIZE-1]}}, opB_i}
             + {{2{opC_i[DSIZE-1]}}, opC_i};
        if (wide > SatMax) begin
            sum_o = {1'b0, {(DSIZE-1){1'b1}}};
        end else if (wide < SatMin) begin
            sum_o = {1'b1, {(DSIZE-1){1'b0}}};
        end else begin
            sum_o = wide[DSIZE-1:0];
        end
        fire_o = (sum_o >= th_i);
    end

endmodule

// File: rtl/nurn_state_updater.sv
// Per-time-step neuron update engine: for each neuron reads Bias, MembPot, Th
// and PostSpikeHist, fetches the synaptic sum, computes the saturated new
// potential and fire decision, and writes MembPot and PostSpikeHist back.
module nurn_state_updater
    import nurn_upd_pkg::*;
#(
    parameter int NUM_NURNS          = 256,
    parameter int DSIZE              = 16,
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int STDP_WIN_BIT_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [NURN_CNT_BIT_WIDTH+1:0] Addr_StatRd_A_o,
    output logic                          rdEn_StatRd_A_o,
    input  logic [DSIZE-1:0]              data_StatRd_A_i,
    output logic [NURN_CNT_BIT_WIDTH+1:0] Addr_StatWr_B_o,
    output logic                          wrEn_StatWr_B_o,
    output logic [DSIZE-1:0]              data_StatWr_B_o,
    output logic                          synReq_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0] synNurnId_o,
    input  logic                          synVld_i,
    input  logic [DSIZE-1:0]              synSum_i,
    output logic                          spike_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0] spikeNurnId_o
);

    localparam logic [NURN_CNT_BIT_WIDTH-1:0] LastIdx = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);

    state_t                          state_q;
    logic [NURN_CNT_BIT_WIDTH-1:0]   nurnIdx_q;
    logic signed [DSIZE-1:0]         bias_q;
    logic signed [DSIZE-1:0]         pot_q;
    logic signed [DSIZE-1:0]         th_q;
    logic signed [DSIZE-1:0]         synSum_q;
    logic [STDP_WIN_BIT_WIDTH-1:0]   hist_q;
    logic                            synFirst_q;
    logic [DSIZE-1:0]                newPot_q;
    logic [STDP_WIN_BIT_WIDTH-1:0]   newHist_q;
    logic                            fire_q;

    logic signed [DSIZE-1:0]         calcSum;
    logic                            calcFire;
    logic [STDP_WIN_BIT_WIDTH-1:0]   histNext;
    logic [1:0]                      rdSel;
    logic [1:0]                      wrSel;

    nurn_sat_add3 #(
        .DSIZE (DSIZE)
    ) u_sat_add3 (
        .opA_i  (pot_q),
        .opB_i  (bias_q),
        .opC_i  (synSum_q),
        .th_i   (th_q),
        .sum_o  (calcSum),
        .fire_o (calcFire)
    );

    // History counts up to all-ones and sticks there; a spike clears it.
    always_comb begin
        if (calcFire) begin
            histNext = '0;
        end else if (&hist_q) begin
            histNext = hist_q;
        end else begin
            histNext = hist_q + STDP_WIN_BIT_WIDTH'(1);
        end
    end

    // Sequencer: walks neurons through read, sync, compute and write-back phases.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            nurnIdx_q  <= '0;
            bias_q     <= '0;
            pot_q      <= '0;
            th_q       <= '0;
            synSum_q   <= '0;
            hist_q     <= '0;
            synFirst_q <= 1'b0;
            newPot_q   <= '0;
            newHist_q  <= '0;
            fire_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        nurnIdx_q <= '0;
                        state_q   <= ST_RD_B;
                    end
                end
                ST_RD_B: state_q <= ST_RD_P;
                ST_RD_P: begin
                    bias_q  <= data_StatRd_A_i;
                    state_q <= ST_RD_T;
                end
                ST_RD_T: begin
                    pot_q   <= data_StatRd_A_i;
                    state_q <= ST_RD_H;
                end
                ST_RD_H: begin
                    th_q       <= data_StatRd_A_i;
                    synFirst_q <= 1'b1;
                    state_q    <= ST_SYN;
                end
                ST_SYN: begin
                    // Hist read data lands in the first SYN cycle only.
                    synFirst_q <= 1'b0;
                    if (synFirst_q) begin
                        hist_q <= data_StatRd_A_i[STDP_WIN_BIT_WIDTH-1:0];
                    end
                    if (synVld_i) begin
                        synSum_q <= synSum_i;
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    newPot_q  <= calcFire ? '0 : calcSum;
                    newHist_q <= histNext;
                    fire_q    <= calcFire;
                    state_q   <= ST_WR_P;
                end
                ST_WR_P: state_q <= ST_WR_H;
                ST_WR_H: begin
                    if (nurnIdx_q == LastIdx) begin
                        state_q <= ST_IDLE;
                    end else begin
                        nurnIdx_q <= nurnIdx_q + NURN_CNT_BIT_WIDTH'(1);
                        state_q   <= ST_RD_B;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Port strobes and selectors decoded from the current state.
    always_comb begin
        rdEn_StatRd_A_o = 1'b0;
        wrEn_StatWr_B_o = 1'b0;
        data_StatWr_B_o = '0;
        synReq_o        = 1'b0;
        spike_o         = 1'b0;
        done_o          = 1'b0;
        rdSel           = SEL_BIAS;
        wrSel           = SEL_BIAS;
        case (state_q)
            ST_RD_B: begin
                rdEn_StatRd_A_o = 1'b1;
                rdSel           = SEL_BIAS;
            end
            ST_RD_P: begin
                rdEn_StatRd_A_o = 1'b1;
                rdSel           = SEL_POT;
            end
            ST_RD_T: begin
                rdEn_StatRd_A_o = 1'b1;
                rdSel           = SEL_TH;
            end
            ST_RD_H: begin
                rdEn_StatRd_A_o = 1'b1;
                rdSel           = SEL_HIST;
            end
            ST_SYN: synReq_o = 1'b1;
            ST_WR_P: begin
                wrEn_StatWr_B_o = 1'b1;
                wrSel           = SEL_POT;
                data_StatWr_B_o = newPot_q;
            end
            ST_WR_H: begin
                wrEn_StatWr_B_o = 1'b1;
                wrSel           = SEL_HIST;
                data_StatWr_B_o = {{(DSIZE-STDP_WIN_BIT_WIDTH){1'b0}}, newHist_q};
                spike_o         = fire_q;
                done_o          = (nurnIdx_q == LastIdx);
            end
            default: ;
        endcase
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign Addr_StatRd_A_o = {nurnIdx_q, rdSel};
    assign Addr_StatWr_B_o = {nurnIdx_q, wrSel};
    assign synNurnId_o     = nurnIdx_q;
    assign spikeNurnId_o   = nurnIdx_q;

endmodule

// File: tb/tb_nurn_state_updater.sv
// Bench for nurn_state_updater with a 4-neuron configuration: a status memory
// model with registered read port, a synaptic responder with per-neuron delay,
// and a reference model computing expected potentials, histories and spikes.
module tb_nurn_state_updater;
    import nurn_upd_pkg::*;

    localparam int N     = 4;
    localparam int DSIZE = 16;
    localparam int IW    = 8;
    localparam int HW    = 8;
    localparam int AW    = IW + 2;

    logic            clk_i = 1'b0;
    logic            rst_n_i, start_i, busy_o, done_o;
    logic [AW-1:0]   Addr_StatRd_A_o, Addr_StatWr_B_o;
    logic            rdEn_StatRd_A_o, wrEn_StatWr_B_o;
    logic [DSIZE-1:0] data_StatRd_A_i, data_StatWr_B_o, synSum_i;
    logic            synReq_o, synVld_i, spike_o;
    logic [IW-1:0]   synNurnId_o, spikeNurnId_o;

    always #5 clk_i = ~clk_i;

    nurn_state_updater #(
        .NUM_NURNS          (N),
        .DSIZE              (DSIZE),
        .NURN_CNT_BIT_WIDTH (IW),
        .STDP_WIN_BIT_WIDTH (HW)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .Addr_StatRd_A_o (Addr_StatRd_A_o),
        .rdEn_StatRd_A_o (rdEn_StatRd_A_o),
        .data_StatRd_A_i (data_StatRd_A_i),
        .Addr_StatWr_B_o (Addr_StatWr_B_o),
        .wrEn_StatWr_B_o (wrEn_StatWr_B_o),
        .data_StatWr_B_o (data_StatWr_B_o),
        .synReq_o        (synReq_o),
        .synNurnId_o     (synNurnId_o),
        .synVld_i        (synVld_i),
        .synSum_i        (synSum_i),
        .spike_o         (spike_o),
        .spikeNurnId_o   (spikeNurnId_o)
    );

    logic [DSIZE-1:0] mem  [0:(1<<AW)-1];
    logic [DSIZE-1:0] snap [0:(1<<AW)-1];
    logic [DSIZE-1:0] synTab [0:N-1];
    int               dlyTab [0:N-1];
    logic [DSIZE-1:0] expPot [0:N-1];
    logic [DSIZE-1:0] expHist [0:N-1];
    int               expSpikes[$];
    int               extraDly;

    int               waitCnt, cyc, checks, failures, t0, doneCyc, doneCnt;
    logic             pendRd;
    logic [AW-1:0]    pendAddr;
    logic [AW-1:0]    wrLog[$];
    int               wrCyc[$];
    int               spikeLog[$];
    int               spikeCyc[$];

    function automatic logic [AW-1:0] mkAddr(input int idx, input logic [1:0] sel);
        return {IW'(idx), sel};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: act on the pre-edge outputs (memory, syn responder, logs), then advance.
    task automatic tick();
        if (synReq_o) begin
            if (waitCnt >= dlyTab[synNurnId_o]) begin
                synVld_i = 1'b1;
                synSum_i = synTab[synNurnId_o];
            end else begin
                synVld_i = 1'b0;
                synSum_i = DSIZE'($urandom);
            end
            waitCnt++;
        end else begin
            synVld_i = 1'($urandom & 1);
            synSum_i = DSIZE'($urandom);
            waitCnt  = 0;
        end
        pendRd   = rdEn_StatRd_A_o;
        pendAddr = Addr_StatRd_A_o;
        if (wrEn_StatWr_B_o) begin
            mem[Addr_StatWr_B_o] = data_StatWr_B_o;
            wrLog.push_back(Addr_StatWr_B_o);
            wrCyc.push_back(cyc);
        end
        if (spike_o) begin
            spikeLog.push_back(int'(spikeNurnId_o));
            spikeCyc.push_back(cyc);
        end
        if (done_o) begin
            doneCnt++;
            doneCyc = cyc;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (pendRd) data_StatRd_A_i = mem[pendAddr];
    endtask

    task automatic setNeuron(input int i, input int b, input int p, input int t, input int h,
                             input int s, input int d);
        mem[mkAddr(i, SEL_BIAS)] = DSIZE'(b);
        mem[mkAddr(i, SEL_POT)]  = DSIZE'(p);
        mem[mkAddr(i, SEL_TH)]   = DSIZE'(t);
        mem[mkAddr(i, SEL_HIST)] = DSIZE'(h);
        synTab[i] = DSIZE'(s);
        dlyTab[i] = d;
    endtask

    task automatic randNeurons(input bit lastFires);
        for (int i = 0; i < N; i++) begin
            int h;
            h = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) h = h | 255;
            setNeuron(i, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 40000)) - 20000, h,
                      int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)));
        end
        if (lastFires) mem[mkAddr(N - 1, SEL_TH)] = 16'h8000;
    endtask

    // Reference: saturated sum of three signed words, threshold fire, sticky history.
    task automatic buildModel();
        for (int a = 0; a < (1 << AW); a++) snap[a] = mem[a];
        expSpikes.delete();
        extraDly = 0;
        for (int i = 0; i < N; i++) begin
            logic signed [DSIZE-1:0] b, p, t, s;
            logic [DSIZE-1:0] hw;
            int sum, h;
            bit fire;
            b = mem[mkAddr(i, SEL_BIAS)];
            p = mem[mkAddr(i, SEL_POT)];
            t = mem[mkAddr(i, SEL_TH)];
            hw = mem[mkAddr(i, SEL_HIST)];
            s = synTab[i];
            sum = int'(p) + int'(b) + int'(s);
            if (sum > 32767) sum = 32767;
            if (sum < -32768) sum = -32768;
            fire = (sum >= int'(t));
            h = int'(hw) % 256;
            expPot[i]  = fire ? '0 : DSIZE'(sum);
            expHist[i] = fire ? '0 : DSIZE'((h == 255) ? 255 : h + 1);
            if (fire) expSpikes.push_back(i);
            extraDly += dlyTab[i];
        end
    endtask

    task automatic clearLogs();
        wrLog.delete();
        wrCyc.delete();
        spikeLog.delete();
        spikeCyc.delete();
        doneCnt = 0;
        doneCyc = -1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_rdEn"}, 32'(rdEn_StatRd_A_o), 0);
        check({tag, "_wrEn"}, 32'(wrEn_StatWr_B_o), 0);
        check({tag, "_synReq"}, 32'(synReq_o), 0);
        check({tag, "_spike"}, 32'(spike_o), 0);
        check({tag, "_addrA"}, 32'(Addr_StatRd_A_o), 0);
        check({tag, "_addrB"}, 32'(Addr_StatWr_B_o), 0);
        check({tag, "_dataB"}, 32'(data_StatWr_B_o), 0);
        check({tag, "_synId"}, 32'(synNurnId_o), 0);
        check({tag, "_spkId"}, 32'(spikeNurnId_o), 0);
    endtask

    // Start a step, optionally poke start_i at a relative cycle and/or with done_o.
    task automatic runStep(input string tag, input int extraStartAt, input bit startAtDone);
        int n;
        clearLogs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        t0 = cyc;
        check({tag, "_first_rd_en"}, 32'(rdEn_StatRd_A_o), 1);
        check({tag, "_first_rd_addr"}, 32'(Addr_StatRd_A_o), 32'(mkAddr(0, SEL_BIAS)));
        n = 0;
        while (doneCnt == 0 && n < 2000) begin
            start_i = ((cyc - t0) == extraStartAt) || (startAtDone && done_o);
            tick();
            n++;
        end
        start_i = 1'b0;
        check({tag, "_done_seen"}, 32'(doneCnt), 1);
    endtask

    task automatic checkStep(input string tag);
        check({tag, "_wr_count"}, 32'(wrLog.size()), 32'(2 * N));
        for (int k = 0; k < wrLog.size() && k < 2 * N; k++) begin
            check($sformatf("%s_wr_addr%0d", tag, k), 32'(wrLog[k]),
                  32'(mkAddr(k / 2, (k % 2 == 1) ? SEL_HIST : SEL_POT)));
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_pot%0d", tag, i), 32'(mem[mkAddr(i, SEL_POT)]), 32'(expPot[i]));
            check($sformatf("%s_hist%0d", tag, i), 32'(mem[mkAddr(i, SEL_HIST)]),
                  32'(expHist[i]));
            check($sformatf("%s_bias%0d", tag, i), 32'(mem[mkAddr(i, SEL_BIAS)]),
                  32'(snap[mkAddr(i, SEL_BIAS)]));
            check($sformatf("%s_th%0d", tag, i), 32'(mem[mkAddr(i, SEL_TH)]),
                  32'(snap[mkAddr(i, SEL_TH)]));
        end
        check({tag, "_spike_count"}, 32'(spikeLog.size()), 32'(expSpikes.size()));
        for (int k = 0; k < spikeLog.size() && k < expSpikes.size(); k++) begin
            check($sformatf("%s_spike_id%0d", tag, k), 32'(spikeLog[k]), 32'(expSpikes[k]));
        end
        check({tag, "_done_cycle"}, 32'(doneCyc - t0 + 1), 32'(8 * N + extraDly));
        tick();
        check({tag, "_busy_fall"}, 32'(busy_o), 0);
        for (int k = 0; k < 3; k++) tick();
        check({tag, "_stay_idle"}, 32'({busy_o, rdEn_StatRd_A_o}), 0);
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0;
        start_i = 1'b0;
        synVld_i = 1'b0;
        synSum_i = '0;
        data_StatRd_A_i = '0;
        waitCnt = 0;
        cyc = 0;
        checks = 0;
        failures = 0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        for (int i = 0; i < N; i++) begin
            synTab[i] = '0;
            dlyTab[i] = 0;
        end
        clearLogs();

        tick();
        tick();
        tick();
        checkIdleOutputs("reset");
        rst_n_i = 1'b1;
        tick();

        // Directed: no-fire, fire at threshold, positive saturation, negative
        // saturation with sticky history and 3-cycle syn delay on the last neuron.
        setNeuron(0, 5, 10, 20, 3, 4, 0);
        setNeuron(1, 5, 10, 20, 3, 6, 0);
        setNeuron(2, 1000, 32000, 32767, 0, 500, 0);
        setNeuron(3, -1000, -32000, 0, 255, 0, 3);
        buildModel();
        runStep("dir", 9, 1'b1);
        if (wrCyc.size() == 2 * N) begin
            check("dir_n0_potwr_cycle", 32'(wrCyc[0] - t0), 6);
            check("dir_n0_histwr_cycle", 32'(wrCyc[1] - t0), 7);
            check("dir_n3_latency", 32'(wrCyc[7] - wrCyc[5]), 11);
        end else begin
            check("dir_wr_cycles_available", 32'(wrCyc.size()), 32'(2 * N));
        end
        checkStep("dir");

        // Randomised steps; the last one forces the final neuron to fire.
        for (int r = 0; r < 5; r++) begin
            randNeurons(r == 4);
            buildModel();
            runStep($sformatf("rnd%0d", r), -100, 1'b0);
            if (r == 4) begin
                check("rnd_last_spike_id", 32'(spikeLog.size() > 0 ? spikeLog[$] : -1),
                      32'(N - 1));
                check("rnd_last_spike_with_done",
                      32'(spikeCyc.size() > 0 ? spikeCyc[$] : -1), 32'(doneCyc));
            end
            checkStep($sformatf("rnd%0d", r));
        end

        // Reset while neuron 2 is reading its threshold.
        randNeurons(1'b0);
        for (int a = 0; a < (1 << AW); a++) snap[a] = mem[a];
        clearLogs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!(rdEn_StatRd_A_o && Addr_StatRd_A_o == mkAddr(2, SEL_TH)) && n < 200) begin
            tick();
            n++;
        end
        check("mid_reset_reached_rdT2", 32'(rdEn_StatRd_A_o && Addr_StatRd_A_o == mkAddr(2, SEL_TH)),
              1);
        rst_n_i = 1'b0;
        tick();
        checkIdleOutputs("mid_reset");
        rst_n_i = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("mid_reset_no_done", 32'(doneCnt), 0);
        check("mid_reset_wr_count", 32'(wrLog.size()), 4);
        for (int i = 2; i < N; i++) begin
            check($sformatf("mid_reset_pot%0d_kept", i), 32'(mem[mkAddr(i, SEL_POT)]),
                  32'(snap[mkAddr(i, SEL_POT)]));
            check($sformatf("mid_reset_hist%0d_kept", i), 32'(mem[mkAddr(i, SEL_HIST)]),
                  32'(snap[mkAddr(i, SEL_HIST)]));
        end
        buildModel();
        runStep("restart", -100, 1'b0);
        checkStep("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nurn_state_updater.md
# nurn_state_updater

Per-time-step neuron state update engine that walks every neuron, reads its Bias, MembPot, Th and PostSpikeHist words through the status memory's registered read port A, and merges in the neuron's integrated synaptic sum. It computes the new membrane potential with saturating signed arithmetic, fires on threshold, and writes MembPot and PostSpikeHist back through status memory write port B. It sits directly upstream of the status memory on ports A/B and downstream of the synaptic integrator, which supplies per-neuron sums through a request/valid handshake.

## Interface
- NUM_NURNS, 256, number of neurons processed per time step
- DSIZE, 16, status word width (signed two's complement)
- NURN_CNT_BIT_WIDTH, 8, neuron index width
- STDP_WIN_BIT_WIDTH, 8, post-spike history width
- clk_i  in  1  single clock; all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- start_i  in  1  one-cycle pulse: begin a time step; ignored while busy_o=1
- busy_o  out  1  high from the cycle after accepted start_i until done_o
- done_o  out  1  one-cycle pulse: last neuron written
- Addr_StatRd_A_o  out  NURN_CNT_BIT_WIDTH+2  {nurnIdx, sel[1:0]}; sel 00 Bias, 01 MembPot, 10 Th, 11 PostSpikeHist
- rdEn_StatRd_A_o  out  1  read enable; data valid on data_StatRd_A_i next cycle and held until the next read
- data_StatRd_A_i  in  DSIZE  registered read data
- Addr_StatWr_B_o  out  NURN_CNT_BIT_WIDTH+2  write address, same format
- wrEn_StatWr_B_o  out  1  write enable
- data_StatWr_B_o  out  DSIZE  write data
- synReq_o  out  1  request synaptic sum for synNurnId_o; held until synVld_i
- synNurnId_o  out  NURN_CNT_BIT_WIDTH  neuron index of request
- synVld_i  in  1  synSum_i valid; sampled only while synReq_o=1
- synSum_i  in  DSIZE  signed synaptic sum
- spike_o  out  1  one-cycle pulse: neuron fired
- spikeNurnId_o  out  NURN_CNT_BIT_WIDTH  index of firing neuron, valid with spike_o

## Operation
- FSM states: IDLE, RD_B, RD_P, RD_T, RD_H, SYN, CALC, WR_P, WR_H.
- IDLE: start_i=1 clears nurnIdx to 0 and goes to RD_B.
- Reads:
  - RD_B issues sel 00.
  - RD_P issues sel 01 and captures bias.
  - RD_T issues sel 10 and captures pot.
  - RD_H issues sel 11 and captures th.
- SYN:
  - First cycle captures hist (low STDP_WIN_BIT_WIDTH bits).
  - synReq_o=1 in every SYN cycle; stays in SYN until synVld_i=1, then captures synSum_i and goes to CALC.
  - Data from the hist read persists across wait cycles.
- CALC:
  - sum = pot + bias + synSum, computed at DSIZE+2 bits signed, saturated to [-2^(DSIZE-1), 2^(DSIZE-1)-1].
  - fire = (sum >= th), signed compare on the saturated value.
  - newPot = fire ? 0 : sum.
  - newHist = fire ? 0 : (hist == all-ones ? hist : hist+1).
- WR_P: writes newPot to sel 01.
- WR_H:
  - Writes newHist zero-extended to DSIZE to sel 11.
  - spike_o = fire, spikeNurnId_o = nurnIdx.
  - If nurnIdx == NUM_NURNS-1: done_o=1, go to IDLE. Else nurnIdx+1, go to RD_B.
- Bias and Th are never written.
- Outside their states, rdEn, wrEn, synReq_o, spike_o and done_o are 0. Address outputs are don't-care but must not toggle X.

## Timing
- Reset (rst_n_i=0 at a clock edge): state IDLE, nurnIdx 0, all outputs 0. Takes priority over every other input.
- Reset mid-step: abandons immediately; no further writes, no done_o. A write already issued on the same edge is not suppressed.
- Per-neuron latency with synVld_i high in the first SYN cycle: 8 cycles. Each synVld_i wait cycle adds 1.
- Full step: 8·NUM_NURNS cycles minimum. busy_o rises the cycle after start_i and falls the cycle after done_o.
- start_i during busy is dropped (no queuing). start_i coincident with done_o is also dropped.
- NUM_NURNS < 2^NURN_CNT_BIT_WIDTH is legal; the index never exceeds NUM_NURNS-1.
- Spike on the last neuron: spike_o and done_o in the same cycle.

## Structure
- Package nurn_upd_pkg holds:
  - state enum
  - SEL_BIAS/SEL_POT/SEL_TH/SEL_HIST = 2'b00/01/10/11
- Sub-module nurn_sat_add3: combinational 3-operand signed add with saturation and threshold compare; outputs sum and fire. Unit-tested separately.

## Test plan
- Neuron 0: bias 5, pot 10, th 20, hist 3, syn 4. Expect pot 19 written, hist 4, no spike, write at cycle 7 after RD_B.
- Same with syn 6. Expect sum 21 ≥ 20: spike_o with id 0, pot 0, hist 0.
- pot 32000, bias 1000, syn 500, th 32767. Expect saturated 32767, spike. pot -32000, bias -1000, th 0 → -32768 written, no spike.
- hist 255, no fire. Expect 255 retained. synVld_i delayed 3 cycles → neuron takes 11 cycles; synSum captured correctly.
- NUM_NURNS=4 full step. Expect exactly 8 port-B writes (sel 01 then 11 per neuron), done_o at cycle 32, a second start_i at cycle 10 ignored.
- rst_n_i low at RD_T of neuron 2. Expect all outputs 0 next cycle; neurons 2–3 untouched; a new start_i restarts at neuron 0.
